riscv_store_mask: RTL and testbench
===================================

// Module: riscv_store_mask
// PURPOSE
//  - Generates the 4-bit byte-write-enable mask for RV32 stores (SB/SH/SW) from the store enable,
//    the address byte offset, and funct3 width.
//  - Sits in the EX/MEM path between the store-data aligner and the data-memory write port.
//  - Mask is purely combinational (zero latency).
//  - Clocked logic only tracks misaligned-store status for the core's exception/debug logic.
// PARAMETERS
//  - none (encodings in package, see STRUCTURE)
// PORTS
//  - clk                input   1  core clock; single clock domain, all state on rising edge
//  - rst                input   1  reset, synchronous, active-high
//  - en                 input   1  store enable; 0 forces mask to 0
//  - offset             input   2  address[1:0], byte offset within word
//  - width              input   3  funct3; only width[1:0] decoded, width[2] ignored
//  - mask               output  4  byte write enables, bit n = byte lane n (combinational)
//  - misaligned         output  1  combinational: en & legal width & illegal offset
//  - misaligned_sticky  output  1  registered: set on any misaligned cycle, cleared only by rst
// BEHAVIOUR
//  - en=0: mask=4'b0000, misaligned=0, regardless of offset/width.
//  - en=1, width[1:0]=0 (byte): offset 0/1/2/3 -> mask 0001/0010/0100/1000.
//  - en=1, width[1:0]=1 (half):
//      - offset 0/1/2 -> mask 0011/0110/1100.
//      - offset 3 -> mask 0000, misaligned=1.
//  - en=1, width[1:0]=2 (word):
//      - offset 0 -> mask 1111.
//      - offset 1/2/3 -> mask 0000, misaligned=1.
//  - en=1, width[1:0]=3 (illegal): mask 0000, misaligned=0.
//  - mask and misaligned settle within the same cycle as input change; no clock dependence.
//  - misaligned_sticky:
//      - Reset value 0.
//      - Each posedge: if rst -> 0; else if misaligned -> 1; else hold.
//  - rst has no effect on combinational outputs; mask is valid during reset.
//  - No X propagation: all case statements have defaults producing 0.
// CONFIGURATION
//  - Macro STORE_MASK_CNT_EN.
//  - Defined:
//      - Adds outputs store_cnt[31:0] and misalign_cnt[31:0].
//      - store_cnt increments each cycle with en=1 and mask!=0.
//      - misalign_cnt increments each cycle with misaligned=1.
//      - Both reset to 0 synchronously and wrap at 2^32-1 -> 0.
//  - Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  - Package riscv_pkg: width encodings BYTE=2'd0, HALF=2'd1, WORD=2'd2, and mask constants
//    (MASK_B0..B3, MASK_H0..H2, MASK_W, MASK_NONE).
//  - Sub-module riscv_store_mask_dec: pure combinational decode (en, offset, width -> mask,
//    misaligned).
//  - Top adds the sticky flag and the optional counters.
// TESTING
//  - en=1, off=0, width=000 -> mask=0001, misaligned=0.
//  - en=1, off=3, width=000 -> mask=1000; off=2, width=001 -> mask=1100.
//  - en=1, off=3, width=001 -> mask=0000, misaligned=1.
//      - Next posedge: misaligned_sticky=1, holds after inputs return to legal.
//  - en=1, off=0, width=010 -> mask=1111; off=1/2/3 -> mask=0000.
//  - en=0, off=0, width=010 -> mask=0000.
//  - en=1, width=011 -> mask=0000, misaligned=0.
//  - width=100 behaves as width=000.
//  - Random: 64+ cycles of random en/offset/width vs golden model, checked 1 ns after drive.
//  - Reset: assert rst one cycle -> sticky (and counters if STORE_MASK_CNT_EN) read 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32 store byte-mask decoder: funct3 width codes and lane masks.
package riscv_pkg;

    localparam logic [1:0] BYTE = 2'd0;
    localparam logic [1:0] HALF = 2'd1;
    localparam logic [1:0] WORD = 2'd2;

    localparam logic [3:0] MASK_NONE = 4'b0000;
    localparam logic [3:0] MASK_B0   = 4'b0001;
    localparam logic [3:0] MASK_B1   = 4'b0010;
    localparam logic [3:0] MASK_B2   = 4'b0100;
    localparam logic [3:0] MASK_B3   = 4'b1000;
    localparam logic [3:0] MASK_H0   = 4'b0011;
    localparam logic [3:0] MASK_H1   = 4'b0110;
    localparam logic [3:0] MASK_H2   = 4'b1100;
    localparam logic [3:0] MASK_W    = 4'b1111;

endpackage

// File: rtl/riscv_store_mask_dec.sv
// Pure combinational decode of store enable, byte offset and width into lane mask and
// misaligned flag. Illegal widths and misaligned offsets yield an empty mask.
module riscv_store_mask_dec
    import riscv_pkg::*;
(
    input  logic       en,
    input  logic [1:0] offset,
    input  logic [1:0] width,
    output logic [3:0] mask,
    output logic       misaligned
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        mask       = MASK_NONE;
        misaligned = 1'b0;
        if (en) begin
            case (width)
                BYTE: begin
                    case (offset)
                        2'd0:    mask = MASK_B0;
                        2'd1:    mask = MASK_B1;
                        2'd2:    mask = MASK_B2;
                        2'd3:    mask = MASK_B3;
                        default: mask = MASK_NONE;
                    endcase
                end
                HALF: begin
                    // Halfwords may straddle lanes 1-2; only offset 3 crosses the word.
                    case (offset)
                        2'd0:    mask = MASK_H0;
                        2'd1:    mask = MASK_H1;
                        2'd2:    mask = MASK_H2;
                        default: misaligned = 1'b1;
                    endcase
                end
                WORD: begin
                    if (offset == 2'd0) mask = MASK_W;
                    else                misaligned = 1'b1;
                end
                default: begin
                    mask       = MASK_NONE;
                    misaligned = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/riscv_store_mask.sv
// RV32 store byte-write-enable generator with sticky misaligned-store flag.
// Define STORE_MASK_CNT_EN to add store and misaligned-store event counters.
module riscv_store_mask
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  offset,
    input  logic [2:0]  width,
    output logic [3:0]  mask,
    output logic        misaligned,
    output logic        misaligned_sticky
`ifdef STORE_MASK_CNT_EN
    ,
    output logic [31:0] store_cnt,
    output logic [31:0] misalign_cnt
`endif
);

    // funct3[2] only distinguishes unsigned loads; stores ignore it.
    logic unused_width_msb;
    assign unused_width_msb = width[2];

    riscv_store_mask_dec u_dec (
        .en         (en),
        .offset     (offset),
        .width      (width[1:0]),
        .mask       (mask),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment for all clocked state avoids evaluation-order races.
        if (rst)             misaligned_sticky <= 1'b0;
        else if (misaligned) misaligned_sticky <= 1'b1;
    end

`ifdef STORE_MASK_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            store_cnt    <= '0;
            misalign_cnt <= '0;
        end else begin
            if (en && (mask != MASK_NONE)) store_cnt <= store_cnt + 32'd1;
            if (misaligned)                misalign_cnt <= misalign_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_riscv_store_mask.sv
// Self-checking bench for riscv_store_mask: directed vector table, sticky-flag sequences,
// and a random run against an arithmetic golden model.
module tb_riscv_store_mask;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  offset;
    logic [2:0]  width;
    logic [3:0]  mask;
    logic        misaligned;
    logic        misaligned_sticky;
`ifdef STORE_MASK_CNT_EN
    logic [31:0] store_cnt;
    logic [31:0] misalign_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    riscv_store_mask dut (
        .clk               (clk),
        .rst               (rst),
        .en                (en),
        .offset            (offset),
        .width             (width),
        .mask              (mask),
        .misaligned        (misaligned),
        .misaligned_sticky (misaligned_sticky)
`ifdef STORE_MASK_CNT_EN
        ,
        .store_cnt         (store_cnt),
        .misalign_cnt      (misalign_cnt)
`endif
    );

    typedef struct {
        logic       en;
        logic [1:0] off;
        logic [2:0] wid;
        logic [3:0] exp_mask;
        logic       exp_mis;
        string      name;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic [1:0] o, input logic [2:0] w);
        @(negedge clk);
        en     = e;
        offset = o;
        width  = w;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Golden model: access covers 2^w bytes from offset and must stay inside the word.
    function automatic void model(input logic e, input logic [1:0] o, input logic [2:0] w,
                                  output logic [3:0] m, output logic mis);
        int size;
        int lanes;
        m   = 4'b0000;
        mis = 1'b0;
        if (e && (w[1:0] != 2'd3)) begin
            size = 1 << int'(w[1:0]);
            if (int'(o) + size <= 4) begin
                lanes = ((1 << size) - 1) << int'(o);
                m     = lanes[3:0];
            end else begin
                mis = 1'b1;
            end
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tick();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] m_exp;
        logic       mis_exp;
        logic       sticky_exp;
        int         st_exp;
        int         ma_exp;

        vecs[0]  = '{1'b1, 2'd0, 3'b000, 4'b0001, 1'b0, "sb_off0"};
        vecs[1]  = '{1'b1, 2'd1, 3'b000, 4'b0010, 1'b0, "sb_off1"};
        vecs[2]  = '{1'b1, 2'd3, 3'b000, 4'b1000, 1'b0, "sb_off3"};
        vecs[3]  = '{1'b1, 2'd0, 3'b001, 4'b0011, 1'b0, "sh_off0"};
        vecs[4]  = '{1'b1, 2'd1, 3'b001, 4'b0110, 1'b0, "sh_off1"};
        vecs[5]  = '{1'b1, 2'd2, 3'b001, 4'b1100, 1'b0, "sh_off2"};
        vecs[6]  = '{1'b1, 2'd3, 3'b001, 4'b0000, 1'b1, "sh_off3"};
        vecs[7]  = '{1'b1, 2'd0, 3'b010, 4'b1111, 1'b0, "sw_off0"};
        vecs[8]  = '{1'b1, 2'd1, 3'b010, 4'b0000, 1'b1, "sw_off1"};
        vecs[9]  = '{1'b1, 2'd2, 3'b010, 4'b0000, 1'b1, "sw_off2"};
        vecs[10] = '{1'b1, 2'd3, 3'b010, 4'b0000, 1'b1, "sw_off3"};
        vecs[11] = '{1'b0, 2'd0, 3'b010, 4'b0000, 1'b0, "en0_sw"};
        vecs[12] = '{1'b0, 2'd3, 3'b001, 4'b0000, 1'b0, "en0_sh_off3"};
        vecs[13] = '{1'b1, 2'd0, 3'b011, 4'b0000, 1'b0, "ill_off0"};
        vecs[14] = '{1'b1, 2'd2, 3'b111, 4'b0000, 1'b0, "ill_w111"};
        vecs[15] = '{1'b1, 2'd0, 3'b100, 4'b0001, 1'b0, "w100_off0"};
        vecs[16] = '{1'b1, 2'd3, 3'b100, 4'b1000, 1'b0, "w100_off3"};
        vecs[17] = '{1'b1, 2'd1, 3'b110, 4'b0000, 1'b1, "w110_off1"};

        rst    = 1'b1;
        en     = 1'b1;
        offset = 2'd1;
        width  = 3'b000;
        tick();
        tick();
        check("rst_sticky", 32'(misaligned_sticky), 32'd0);
        check("rst_mask_valid", 32'(mask), 32'b0010);
`ifdef STORE_MASK_CNT_EN
        check("rst_store_cnt", store_cnt, 32'd0);
        check("rst_misalign_cnt", misalign_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Sticky sequence: legal and disabled-misaligned stores leave it clear.
        drive(1'b1, 2'd2, 3'b001);
        tick();
        check("sticky_legal", 32'(misaligned_sticky), 32'd0);
        drive(1'b0, 2'd3, 3'b010);
        tick();
        check("sticky_en0", 32'(misaligned_sticky), 32'd0);
        drive(1'b1, 2'd3, 3'b001);
        check("seq_mis_mask", 32'(mask), 32'd0);
        check("seq_mis_flag", 32'(misaligned), 32'd1);
        check("seq_sticky_before_edge", 32'(misaligned_sticky), 32'd0);
        tick();
        check("sticky_set", 32'(misaligned_sticky), 32'd1);
        drive(1'b1, 2'd0, 3'b010);
        check("seq_legal_mis", 32'(misaligned), 32'd0);
        tick();
        tick();
        check("sticky_hold", 32'(misaligned_sticky), 32'd1);
        do_reset();
        #1;
        check("sticky_cleared", 32'(misaligned_sticky), 32'd0);

`ifdef STORE_MASK_CNT_EN
        // 3 effective stores, 2 misaligned, 1 disabled, 1 illegal width.
        drive(1'b1, 2'd0, 3'b000); tick();
        drive(1'b1, 2'd2, 3'b001); tick();
        drive(1'b1, 2'd0, 3'b010); tick();
        drive(1'b1, 2'd1, 3'b010); tick();
        drive(1'b1, 2'd3, 3'b001); tick();
        drive(1'b0, 2'd0, 3'b010); tick();
        drive(1'b1, 2'd0, 3'b011); tick();
        check("cnt_store", store_cnt, 32'd3);
        check("cnt_misalign", misalign_cnt, 32'd2);
        do_reset();
        #1;
        check("cnt_store_rst", store_cnt, 32'd0);
        check("cnt_misalign_rst", misalign_cnt, 32'd0);
`endif

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].off, vecs[i].wid);
            check({vecs[i].name, "_mask"}, 32'(mask), 32'(vecs[i].exp_mask));
            check({vecs[i].name, "_mis"}, 32'(misaligned), 32'(vecs[i].exp_mis));
        end

        do_reset();
        sticky_exp = 1'b0;
        st_exp     = 0;
        ma_exp     = 0;
        for (int i = 0; i < 80; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)));
            model(en, offset, width, m_exp, mis_exp);
            check($sformatf("rnd%0d_mask", i), 32'(mask), 32'(m_exp));
            check($sformatf("rnd%0d_mis", i), 32'(misaligned), 32'(mis_exp));
            if (mis_exp) begin
                sticky_exp = 1'b1;
                ma_exp++;
            end
            if (m_exp != 4'b0000) st_exp++;
            tick();
            check($sformatf("rnd%0d_sticky", i), 32'(misaligned_sticky), 32'(sticky_exp));
`ifdef STORE_MASK_CNT_EN
            check($sformatf("rnd%0d_store_cnt", i), store_cnt, 32'(st_exp));
            check($sformatf("rnd%0d_misalign_cnt", i), misalign_cnt, 32'(ma_exp));
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
